shift_sequencer: RTL and testbench

Multi-cycle controller for register-specified shifts (ARM "Rm, <shift> Rs") in the EXE stage. The immediate-shift operand generator covers shift-by-immediate; this block handles the shift amount from Rs[7:0]. It shifts one bit per cycle, produces the shifted value and the shifter carry-out, and stalls the pipeline for the duration of the operation.

---
 rtl/shift_sequencer_pkg.sv | 35 +++
 rtl/shift_sequencer_step.sv | 37 +++
 rtl/shift_sequencer.sv | 112 +++++++++++
 tb/tb_shift_sequencer.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/shift_sequencer_pkg.sv
// Shared definitions for the register-specified shift sequencer:
// shift-type encodings, controller states and the shift-count clamp.
package shift_sequencer_pkg;

    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    // 33 single-bit steps are enough to reach the final value and carry
    // of any LSL/LSR/ASR amount from 33 up to 255.
    localparam logic [5:0] SH_CLAMP = 6'd33;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } sh_state_t;

    // Number of single-bit steps for a given type and Rs[7:0].
    // ROR only ever needs the amount modulo 32.
    function automatic logic [5:0] sh_step_count(input logic [1:0] t,
                                                 input logic [7:0] amt);
        logic [5:0] n;
        if (t == SH_ROR) begin
            n = {1'b0, amt[4:0]};
        end else if (amt > {2'b00, SH_CLAMP}) begin
            n = SH_CLAMP;
        end else begin
            n = amt[5:0];
        end
        return n;
    endfunction

endpackage

// File: rtl/shift_sequencer_step.sv
// Combinational single-bit shift step. Given the current work value,
// carry and shift type, produces the value and carry after one step.
module shift_step
    import shift_sequencer_pkg::*;
(
    input  logic [31:0] i_work,
    input  logic        i_carry,
    input  logic [1:0]  i_type,
    output logic [31:0] o_work,
    output logic        o_carry
);

    // One-bit shift/rotate; the outgoing bit becomes the new carry.
    always_comb begin
        o_work  = i_work;
        o_carry = i_carry;
        case (i_type)
            SH_LSL: begin
                o_carry = i_work[31];
                o_work  = {i_work[30:0], 1'b0};
            end
            SH_LSR: begin
                o_carry = i_work[0];
                o_work  = {1'b0, i_work[31:1]};
            end
            SH_ASR: begin
                o_carry = i_work[0];
                o_work  = {i_work[31], i_work[31:1]};
            end
            default: begin
                o_carry = i_work[0];
                o_work  = {i_work[0], i_work[31:1]};
            end
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle controller for register-specified shifts in EXE.
// Shifts one bit per cycle, stalling the pipeline until the result and
// shifter carry are presented together with a one-cycle done pulse.
module shift_sequencer
    import shift_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] val_rm,
    input  logic [1:0]  shift_type,
    input  logic [7:0]  shift_amt,
    input  logic        carry_in,
    output logic [31:0] result,
    output logic        carry_out,
    output logic        busy,
    output logic        done,
    output logic        stall
);

    sh_state_t   r_state;
    sh_state_t   w_state_next;
    logic [5:0]  r_count;
    logic [31:0] r_work;
    logic        r_carry;
    logic [1:0]  r_type;

    logic [5:0]  w_load_count;
    logic        w_ror_wrap;
    logic        w_accept;
    logic [31:0] w_step_work;
    logic        w_step_carry;

    // A ROR by a non-zero multiple of 32 leaves the value intact but
    // still reports bit 31 as the carry, so it is loaded up front.
    assign w_ror_wrap   = (shift_type == SH_ROR) && (shift_amt != 8'd0)
                          && (shift_amt[4:0] == 5'd0);
    assign w_load_count = sh_step_count(shift_type, shift_amt);
    assign w_accept     = (r_state == ST_IDLE) && start;

    shift_step u_step (
        .i_work  (r_work),
        .i_carry (r_carry),
        .i_type  (r_type),
        .o_work  (w_step_work),
        .o_carry (w_step_carry)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and status outputs.
    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        stall        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    stall        = 1'b1;
                    w_state_next = (w_load_count == 6'd0) ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                busy  = 1'b1;
                stall = 1'b1;
                if (r_count == 6'd1) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                busy         = 1'b1;
                done         = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Work/carry registers and step counter: load on accept, step in SHIFT,
    // otherwise hold so the result stays visible until the next start.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_work  <= 32'd0;
            r_carry <= 1'b0;
            r_count <= 6'd0;
            r_type  <= SH_LSL;
        end else if (w_accept) begin
            r_work  <= val_rm;
            r_type  <= shift_type;
            r_carry <= w_ror_wrap ? val_rm[31] : carry_in;
            r_count <= w_load_count;
        end else if (r_state == ST_SHIFT) begin
            r_work  <= w_step_work;
            r_carry <= w_step_carry;
            r_count <= r_count - 6'd1;
        end
    end

    assign result    = r_work;
    assign carry_out = r_carry;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed cases plus random
// operations compared against an arithmetic model of ARM shift semantics.
module tb_shift_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] val_rm;
    logic [1:0]  shift_type;
    logic [7:0]  shift_amt;
    logic        carry_in;
    logic [31:0] result;
    logic        carry_out;
    logic        busy;
    logic        done;
    logic        stall;

    int total;
    int bad;

    shift_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .val_rm     (val_rm),
        .shift_type (shift_type),
        .shift_amt  (shift_amt),
        .carry_in   (carry_in),
        .result     (result),
        .carry_out  (carry_out),
        .busy       (busy),
        .done       (done),
        .stall      (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ARM shifter semantics computed with wide arithmetic shifts.
    function automatic logic [32:0] ref_shift(input logic [31:0] v, input logic [1:0] t,
                                              input logic [7:0] a, input logic ci);
        logic [63:0]        x;
        logic signed [63:0] s;
        logic [31:0]        r;
        int                 m;
        if (a == 8'd0) return {ci, v};
        case (t)
            2'b00: begin x = {32'd0, v} << a; return {x[32], x[31:0]}; end
            2'b01: begin x = {v, 32'd0} >> a; return {x[31], x[63:32]}; end
            2'b10: begin s = $signed({v, 32'd0}); x = s >>> a; return {x[31], x[63:32]}; end
            default: begin
                m = int'(a) % 32;
                x = {v, v} >> m;
                r = x[31:0];
                return {r[31], r};
            end
        endcase
    endfunction

    // Cycles from the accepting edge to the first cycle with done high.
    function automatic int ref_latency(input logic [1:0] t, input logic [7:0] a);
        int n;
        if (t == 2'b11) n = int'(a) % 32;
        else n = (int'(a) > 33) ? 33 : int'(a);
        return n + 1;
    endfunction

    task automatic run_op(input string tag, input logic [31:0] v, input logic [1:0] t,
                          input logic [7:0] a, input logic ci);
        logic [32:0] exp;
        int k;
        exp = ref_shift(v, t, a, ci);
        @(negedge clk);
        val_rm = v; shift_type = t; shift_amt = a; carry_in = ci; start = 1'b1;
        #1;
        chk({tag, ":stall_req"}, {31'd0, stall}, 32'd1);
        @(posedge clk); #1;
        start = 1'b0;
        k = 1;
        while (!done && k < 40) begin
            if (busy !== 1'b1 || stall !== 1'b1) chk({tag, ":busy_stall_shift"}, {30'd0, busy, stall}, 32'd3);
            @(posedge clk); #1;
            k++;
        end
        chk({tag, ":done"}, {31'd0, done}, 32'd1);
        chk({tag, ":latency"}, k, ref_latency(t, a));
        chk({tag, ":result"}, result, exp[31:0]);
        chk({tag, ":carry"}, {31'd0, carry_out}, {31'd0, exp[32]});
        chk({tag, ":stall_done"}, {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        chk({tag, ":idle_after"}, {30'd0, busy, done}, 32'd0);
    endtask

    initial begin
        logic [32:0] e;
        int pulses;
        total = 0; bad = 0;
        rst = 1'b1; start = 1'b0; val_rm = 32'd0; shift_type = 2'b00;
        shift_amt = 8'd0; carry_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_result", result, 32'd0);
        chk("reset_flags", {28'd0, carry_out, busy, done, stall}, 32'd0);
        @(negedge clk); rst = 1'b0;

        // Directed cases
        run_op("lsl4",    32'h8000_000F, 2'b00, 8'd4,   1'b0);
        run_op("lsr32",   32'h8000_0001, 2'b01, 8'd32,  1'b0);
        run_op("lsr200",  32'h8000_0001, 2'b01, 8'd200, 1'b1);
        run_op("lsl32",   32'h0000_0001, 2'b00, 8'd32,  1'b0);
        run_op("lsl33",   32'hFFFF_FFFF, 2'b00, 8'd33,  1'b1);
        run_op("asr40",   32'h8000_0000, 2'b10, 8'd40,  1'b0);
        run_op("ror8",    32'h1234_5678, 2'b11, 8'd8,   1'b1);
        run_op("amt0",    32'hDEAD_BEEF, 2'b01, 8'd0,   1'b1);
        run_op("ror32",   32'h8000_0000, 2'b11, 8'd32,  1'b0);
        run_op("ror64",   32'h7000_0000, 2'b11, 8'd64,  1'b1);
        run_op("asr31",   32'h4000_0000, 2'b10, 8'd31,  1'b1);

        // Start held high: one accept per N+2 cycles, one done per op
        e = ref_shift(32'h0000_0003, 2'b00, 8'd2, 1'b0);
        @(negedge clk);
        val_rm = 32'h0000_0003; shift_type = 2'b00; shift_amt = 8'd2; carry_in = 1'b0;
        start = 1'b1;
        pulses = 0;
        for (int c = 0; c < 16; c++) begin
            @(posedge clk); #1;
            if (done) begin
                pulses++;
                chk("held_result", result, e[31:0]);
            end
            chk("held_stall", {31'd0, stall}, {31'd0, (busy && !done) || (!busy && start)});
        end
        chk("held_pulses", pulses, 4);
        @(negedge clk); start = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk("held_idle", {31'd0, busy}, 32'd0);

        // Reset mid-shift
        @(negedge clk);
        val_rm = 32'hA5A5_A5A5; shift_type = 2'b00; shift_amt = 8'd19; carry_in = 1'b1;
        start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_result", result, 32'd0);
        chk("rst_mid_flags", {28'd0, carry_out, busy, done, stall}, 32'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_no_done", {31'd0, done}, 32'd0);
        run_op("after_rst", 32'hA5A5_A5A5, 2'b10, 8'd5, 1'b0);

        // Random operations
        for (int i = 0; i < 40; i++) begin
            logic [7:0] a;
            a = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                            : 8'($urandom_range(0, 40));
            run_op("rand", $urandom, 2'($urandom_range(0, 3)), a, 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
